linebuf_dbl: RTL
================

# linebuf_dbl

Parametrised double-buffered line attribute buffer for the video pipeline. The sprite/tile renderer writes the next scanline's per-pixel attributes into a back bank while video output reads the current line from a front bank. Banks exchange on a line-boundary `swap` pulse. The newly exposed back bank is then automatically swept to `CLEAR_VALUE`. This generalises the single-bank 512×1 line attribute buffer in width, depth and clearing behaviour.

## Interface
- `WIDTH`, 1: bits per entry.
- `DEPTH`, 512: entries per bank; any value ≥ 2, not required to be a power of two.
- `CLEAR_VALUE`, 0: WIDTH-bit value written by the sweeps.
- `AW`, `$clog2(DEPTH)`: derived index width; not to be overridden.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `wr_idx  in  AW`: write index into the back bank.
- `wr_data  in  WIDTH`: write data.
- `wr_en  in  1`: write request; accepted only when `wr_ready`=1.
- `wr_ready  out  1`: high in IDLE only.
- `rd_idx  in  AW`: read index into the front bank.
- `rd_data  out  WIDTH`: registered read data.
- `swap  in  1`: single-cycle pulse at line end; exchanges banks.
- `front  out  1`: index of the current front bank.
- `overrun  out  1`: one-cycle pulse when `swap` arrives during CLEAR.

## Operation
- FSM states and transitions:
  - INIT: entered on reset. Sweeps both banks with `CLEAR_VALUE`, one entry per cycle, indices 0..DEPTH-1. Goes to IDLE after DEPTH-1 is written.
  - IDLE: accepts writes to bank `~front`. On `swap`, toggles `front` and goes to CLEAR with the sweep counter at 0.
  - CLEAR: sweeps bank `~front` (the new front's old partner). Goes to IDLE after DEPTH-1 is written.
- `swap` in INIT is ignored; `overrun` stays 0.
- `swap` in CLEAR:
  - toggles `front`;
  - restarts the sweep at index 0 on the new back bank;
  - pulses `overrun`.
- Write rules:
  - A write is performed when `wr_en & wr_ready` and `wr_idx < DEPTH`.
  - `wr_idx ≥ DEPTH` is dropped silently.
  - `wr_en` while `wr_ready`=0 is dropped; there is no queueing.
- Read rules:
  - Reads always target bank `front`.
  - `rd_idx ≥ DEPTH` returns `CLEAR_VALUE`.
  - Reads are allowed in every state.
- Sweep counter width is AW. The end condition is a compare against DEPTH-1, never counter wrap-around.

## Timing
- Reset values: `front`=0, `rd_data`=`CLEAR_VALUE`, `wr_ready`=0, `overrun`=0, state=INIT, sweep counter=0. RAM contents are undefined until INIT completes.
- INIT lasts exactly DEPTH cycles after `reset_n` deasserts. `wr_ready` rises in cycle DEPTH.
- Read latency is 1 cycle: `rd_data` at edge N+1 reflects `rd_idx` and `front` sampled at edge N.
- Swap cycle:
  - `rd_idx` sampled in the `swap` cycle reads the old front.
  - A write accepted in the `swap` cycle lands in the old back bank, which is the new front.
  - `wr_ready` drops in the following cycle and stays low for exactly DEPTH cycles.
- Write-then-read of the same bank becomes visible on the cycle after the write edge. Reading a freshly written entry after swap therefore has 1-cycle latency.
- `reset_n` asserted mid-sweep:
  - immediately forces the reset values above;
  - the sweep restarts from INIT on release;
  - any partially cleared contents are irrelevant.
- `overrun` is high for exactly one cycle per offending `swap`.

## Structure
- Shared package `linebuf_pkg` holds:
  - state encodings `ST_INIT`, `ST_IDLE`, `ST_CLEAR` (2 bits);
  - the derived-width helper used for AW.
- One sub-module, `linebuf_bank`: a single DEPTH×WIDTH bank with synchronous write and asynchronous read, mapping to distributed RAM. It is instantiated twice.
- The top level contains:
  - the FSM;
  - the sweep counter;
  - the write-enable/address/data muxing (sweep vs. renderer);
  - the front-bank read mux;
  - the `rd_data` register.

## Test plan
- Reset with DEPTH=512, WIDTH=1, CLEAR_VALUE=0 → `wr_ready`=0 for 512 cycles then 1. Every `rd_idx` 0..511 reads 0 in both banks (swap once, reread).
- In IDLE, write 1 to idx 5 and idx 511, then `swap`, read idx 5/511/6 → 1/1/0 with 1-cycle latency. After 512 more cycles, swap back and read idx 5 → 0 (cleared).
- WIDTH=4, DEPTH=320, CLEAR_VALUE=4'hF → after INIT, reads of idx 0..319 = F and idx 400 = F. A write to idx 330 is dropped with no effect on any entry.
- `swap` 100 cycles into CLEAR (DEPTH=512) → `overrun` pulses once, `front` toggles, `wr_ready` stays low for a further 512 cycles.
- `wr_en` asserted every cycle during CLEAR with `wr_data`=1 → no entry of the back bank is 1 when `wr_ready` rises.
- Assert `reset_n` mid-CLEAR → all outputs take reset values asynchronously before the next edge. `front`=0 and INIT runs DEPTH cycles again.

Source files
------------

// File: rtl/linebuf_pkg.sv
// Shared definitions for the double-buffered line attribute buffer:
// FSM state encodings and the index-width helper.
package linebuf_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Index width for a bank of the given depth (never narrower than 1 bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/linebuf_bank.sv
// One DEPTH x WIDTH attribute bank: synchronous write, asynchronous read,
// intended to map onto distributed RAM.
module linebuf_bank #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/linebuf_dbl.sv
// Double-buffered line attribute buffer: renderer writes the back bank, video
// reads the front bank, banks exchange on swap and the new back bank is swept.
module linebuf_dbl
  import linebuf_pkg::*;
#(
  parameter int                  WIDTH       = 1,
  parameter int                  DEPTH       = 512,
  parameter logic [WIDTH-1:0]    CLEAR_VALUE = '0,
  parameter int                  AW          = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic             swap,
  output logic             front,
  output logic             overrun
);

  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t          state, state_next;
  logic [AW-1:0]   sweep_cnt, cnt_next;
  logic            front_next, overrun_next;
  logic [1:0]      sweep_we;
  logic            user_we, in_sweep;
  logic [1:0]      bank_we;
  logic [AW-1:0]   waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata0, rdata1, rd_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      front     <= 1'b0;
      overrun   <= 1'b0;
      rd_data   <= CLEAR_VALUE;
    end else begin
      state     <= state_next;
      sweep_cnt <= cnt_next;
      front     <= front_next;
      overrun   <= overrun_next;
      rd_data   <= rd_next;
    end
  end

  // A swap during CLEAR takes priority over finishing the current sweep.
  always_comb begin
    state_next   = state;
    cnt_next     = sweep_cnt;
    front_next   = front;
    overrun_next = 1'b0;
    sweep_we     = 2'b00;
    case (state)
      ST_INIT: begin
        sweep_we = 2'b11;
        if (sweep_cnt == LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sweep_cnt + AW'(1);
        end
      end
      ST_IDLE: begin
        if (swap) begin
          front_next = ~front;
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        sweep_we = front ? 2'b01 : 2'b10;
        if (swap) begin
          front_next   = ~front;
          cnt_next     = '0;
          overrun_next = 1'b1;
        end else if (sweep_cnt == LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sweep_cnt + AW'(1);
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign wr_ready = (state == ST_IDLE);
  assign in_sweep = (state != ST_IDLE);
  assign user_we  = wr_en & wr_ready & ({1'b0, wr_idx} < DEPTH_C);

  assign bank_we[0] = sweep_we[0] | (user_we & front);
  assign bank_we[1] = sweep_we[1] | (user_we & ~front);
  assign waddr      = in_sweep ? sweep_cnt : wr_idx;
  assign wdata      = in_sweep ? CLEAR_VALUE : wr_data;

  linebuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_idx),
    .rdata (rdata0)
  );

  linebuf_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_idx),
    .rdata (rdata1)
  );

  always_comb begin
    rd_next = CLEAR_VALUE;
    if ({1'b0, rd_idx} < DEPTH_C) rd_next = front ? rdata1 : rdata0;
  end

endmodule
